// File: rtl/booth_divider.sv
// Signed 16/8 restoring divider, truncating toward zero.
// One quotient bit per cycle in CALC; signs and error cases are applied in FIX.
module booth_divider (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [8:0]  prem;
    logic [15:0] qm;
    logic [7:0]  dvs;
    logic [7:0]  dlo;
    logic        sd;
    logic        sx;
    logic        zf;
    logic        of;
    logic [8:0]  shifted;
    logic [9:0]  diff;

    // Handshake: start is honoured only in IDLE; done pulses for one cycle
    // with quotient/remainder/err valid from that cycle until the next FIX.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == 5'd15) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Partial remainder stays below |divisor| <= 128, so the shifted value fits 9 bits.
    assign shifted = {prem[7:0], qm[15]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= 5'd0;
            prem      <= 9'd0;
            qm        <= 16'd0;
            dvs       <= 8'd0;
            dlo       <= 8'd0;
            sd        <= 1'b0;
            sx        <= 1'b0;
            zf        <= 1'b0;
            of        <= 1'b0;
            quotient  <= 16'd0;
            remainder <= 8'd0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        // 0x8000 negates to itself, which is 32768 read unsigned.
                        qm   <= dividend[15] ? 16'(-dividend) : dividend;
                        dvs  <= divisor[7] ? 8'(-divisor) : divisor;
                        dlo  <= dividend[7:0];
                        sd   <= dividend[15];
                        sx   <= dividend[15] ^ divisor[7];
                        zf   <= (divisor == 8'd0);
                        of   <= (dividend == 16'h8000) && (divisor == 8'hFF);
                        prem <= 9'd0;
                        cnt  <= 5'd0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (!diff[9]) begin
                        prem <= diff[8:0];
                        qm   <= {qm[14:0], 1'b1};
                    end else begin
                        prem <= shifted;
                        qm   <= {qm[14:0], 1'b0};
                    end
                end
                FIX: begin
                    if (zf) begin
                        quotient  <= sd ? 16'h8000 : 16'h7FFF;
                        remainder <= dlo;
                        err       <= 1'b1;
                    end else if (of) begin
                        quotient  <= 16'h7FFF;
                        remainder <= 8'h00;
                        err       <= 1'b1;
                    end else begin
                        quotient  <= sx ? 16'(-qm) : qm;
                        remainder <= sd ? 8'(-prem[7:0]) : prem[7:0];
                        err       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Directed-vector bench for booth_divider: table of signed cases, handshake,
// mid-operation reset and a randomised run against an integer-division model.
module tb_booth_divider;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        err;
    logic [1:0]  dbg_state;

    int tests;
    int fails;

    logic [24:0] exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        e;
    } vec_t;

    vec_t vecs[12];

    booth_divider dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division with the two error overrides.
    function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int q;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return {(sa < 0) ? 16'h8000 : 16'h7FFF, a[7:0], 1'b1};
        if (sa == -32768 && sb == -1) return {16'h7FFF, 8'h00, 1'b1};
        q = sa / sb;
        r = sa % sb;
        return {16'(q), 8'(r), 1'b0};
    endfunction

    // Driver: called at a negedge; returns at a negedge one cycle after done.
    task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                          output logic [15:0] q, output logic [7:0] r, output logic e);
        int          n;
        logic        busy_ok;
        logic        hold_ok;
        logic [24:0] held;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        held     = {quotient, remainder, err};
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        n        = 0;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if ({quotient, remainder, err} !== held) hold_ok = 1'b0;
            @(posedge CLK);
            n++;
            @(negedge CLK);
        end
        check({name, " latency"}, n, 17);
        check({name, " busy during op"}, busy_ok, 1'b1);
        check({name, " outputs held"}, hold_ok, 1'b1);
        check({name, " busy at done"}, busy, 1'b0);
        q = quotient;
        r = remainder;
        e = err;
        @(posedge CLK);
        @(negedge CLK);
        check({name, " done one cycle"}, done, 1'b0);
    endtask

    initial begin
        logic [15:0] q;
        logic [7:0]  r;
        logic        e;
        logic [24:0] exp;
        int          n;
        int          done_cnt;

        tests = 0;
        fails = 0;

        vecs[0]  = '{"100/7",       16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0};
        vecs[1]  = '{"-100/7",      16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0};
        vecs[2]  = '{"100/-7",      16'h0064, 8'hF9, 16'hFFF2, 8'h02, 1'b0};
        vecs[3]  = '{"-100/-7",     16'hFF9C, 8'hF9, 16'h000E, 8'hFE, 1'b0};
        vecs[4]  = '{"-32768/1",    16'h8000, 8'h01, 16'h8000, 8'h00, 1'b0};
        vecs[5]  = '{"-32768/-128", 16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0};
        vecs[6]  = '{"32767/-128",  16'h7FFF, 8'h80, 16'hFF01, 8'h7F, 1'b0};
        vecs[7]  = '{"5/0",         16'h0005, 8'h00, 16'h7FFF, 8'h05, 1'b1};
        vecs[8]  = '{"-5/0",        16'hFFFB, 8'h00, 16'h8000, 8'hFB, 1'b1};
        vecs[9]  = '{"-32768/-1",   16'h8000, 8'hFF, 16'h7FFF, 8'h00, 1'b1};
        vecs[10] = '{"6/3",         16'h0006, 8'h03, 16'h0002, 8'h00, 1'b0};
        vecs[11] = '{"32767/127",   16'h7FFF, 8'h7F, 16'h0102, 8'h01, 1'b0};

        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        RST      = 1'b1;
        #12;
        check("reset quotient", quotient, 16'h0000);
        check("reset remainder", remainder, 8'h00);
        check("reset err", err, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset state", dbg_state, 2'd0);

        // Release and issue start for the very first edge after reset.
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, q, r, e);
            check({vecs[i].name, " quotient"}, q, vecs[i].q);
            check({vecs[i].name, " remainder"}, r, vecs[i].r);
            check({vecs[i].name, " err"}, e, vecs[i].e);
        end

        // Handshake: starts mid-op are ignored; a start on the done cycle is taken.
        dividend = 16'd1000;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        n     = 0;
        while (!done && n < 40) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (n == 3 || n == 10) begin
                start    = 1'b1;
                dividend = 16'h1234;
                divisor  = 8'h03;
            end else begin
                start = 1'b0;
            end
        end
        check("hs first latency", n, 17);
        check("hs first quotient", quotient, 16'h006F);
        check("hs first remainder", remainder, 8'h01);
        check("hs first err", err, 1'b0);
        dividend = 16'd77;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        n     = 1;
        while (!done && n < 40) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
        end
        check("hs done spacing", n, 18);
        check("hs second quotient", quotient, 16'h000F);
        check("hs second remainder", remainder, 8'h02);

        // Asynchronous reset in the middle of CALC.
        @(negedge CLK);
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("async rst quotient", quotient, 16'h0000);
        check("async rst remainder", remainder, 8'h00);
        check("async rst err", err, 1'b0);
        check("async rst busy", busy, 1'b0);
        check("async rst state", dbg_state, 2'd0);
        @(negedge CLK);
        RST      = 1'b0;
        done_cnt = 0;
        repeat (25) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        check("aborted op no done", done_cnt, 0);
        run_op("post-rst 100/7", 16'd100, 8'd7, q, r, e);
        check("post-rst quotient", q, 16'h000E);
        check("post-rst remainder", r, 8'h02);
        check("post-rst err", e, 1'b0);

        // Random operands scored against the integer model.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = 8'($urandom);
            if (i % 64 == 0) b = 8'h00;
            if (i % 97 == 0) begin
                a = 16'h8000;
                b = 8'hFF;
            end
            exp_q.push_back(model(a, b));
            run_op("rand", a, b, q, r, e);
            exp = exp_q.pop_front();
            check("rand result", {q, r, e}, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
